// File: rtl/ristretto_clint_pkg.sv
// Shared constants and helpers for the core-local interruptor (CLINT).
// Register offsets, reset values, the decoded register select and byte-merge helper.
package ristretto_clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    RegMsip,
    RegMtimecmpLo,
    RegMtimecmpHi,
    RegMtimeLo,
    RegMtimeHi,
    RegNone
  } clint_reg_e;

  // Map a 16-bit bus offset onto a register select; anything else is unmapped.
  function automatic clint_reg_e clint_decode(input logic [15:0] off);
    clint_reg_e sel;
    case (off)
      MSIP_OFF:        sel = RegMsip;
      MTIMECMP_LO_OFF: sel = RegMtimecmpLo;
      MTIMECMP_HI_OFF: sel = RegMtimecmpHi;
      MTIME_LO_OFF:    sel = RegMtimeLo;
      MTIME_HI_OFF:    sel = RegMtimeHi;
      default:         sel = RegNone;
    endcase
    return sel;
  endfunction

  // Replace only the enabled bytes of old_val with the corresponding write-data bytes.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ristretto_clint_prescaler.sv
// mtime tick divider: tick_o pulses once every PrescaleDiv cycles.
// clear_i restarts the phase so the first tick follows PrescaleDiv cycles later.
module ristretto_clint_prescaler #(
  parameter int unsigned PrescaleDiv = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PrescaleDiv - 1);

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntMax);

  // Free-running modulo-PrescaleDiv phase counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ristretto_core_local_interruptor.sv
// Core-local interruptor: mtime / mtimecmp / msip behind a req/gnt/rvalid slave port,
// driving level timer and software interrupts into the trap control unit.
// Optional feature macro: RISTRETTO_CLINT_PRESCALER_EN (mtime advances every PrescaleDiv cycles).
module ristretto_core_local_interruptor
  import ristretto_clint_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned PrescaleDiv = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [AddrWidth-1:0] bus_addr_i,
  input  logic [3:0]           bus_be_i,
  input  logic [DataWidth-1:0] bus_wdata_i,
  output logic                 bus_gnt_o,
  output logic                 bus_rvalid_o,
  output logic [DataWidth-1:0] bus_rdata_o,
  output logic                 bus_err_o,
  output logic                 tim_intr_o,
  output logic                 sw_intr_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        rvalid_q, err_q, tim_intr_q, sw_intr_q;
  logic [31:0] rdata_q;

  clint_reg_e  sel;
  logic        wr_en, rd_en, tick;
  logic [31:0] cur_val, merged;

  // Only offset bits [15:0] take part in decode.
  logic unused_addr;
  assign unused_addr = ^bus_addr_i;

  assign sel   = clint_decode(bus_addr_i[15:0]);
  assign wr_en = bus_req_i & bus_we_i;
  assign rd_en = bus_req_i & ~bus_we_i;

`ifdef RISTRETTO_CLINT_PRESCALER_EN
  logic mtime_wr;
  assign mtime_wr = wr_en & ((sel == RegMtimeLo) | (sel == RegMtimeHi));

  ristretto_clint_prescaler #(
    .PrescaleDiv(PrescaleDiv)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear_i(mtime_wr),
    .tick_o (tick)
  );
`else
  localparam int unsigned unused_prescale_div = PrescaleDiv;
  assign tick = 1'b1;
`endif

  // Selected register value; feeds both the read path and the byte merge on writes.
  always_comb begin
    cur_val = '0;
    case (sel)
      RegMsip:       cur_val = {31'b0, msip_q};
      RegMtimecmpLo: cur_val = mtimecmp_q[31:0];
      RegMtimecmpHi: cur_val = mtimecmp_q[63:32];
      RegMtimeLo:    cur_val = mtime_q[31:0];
      RegMtimeHi:    cur_val = mtime_q[63:32];
      default:       cur_val = '0;
    endcase
    merged = be_merge(cur_val, bus_wdata_i[31:0], bus_be_i);
  end

  // Next-state for the architectural registers; an mtime write overrides that cycle's tick.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en) begin
      case (sel)
        RegMsip:       msip_d            = merged[0];
        RegMtimecmpLo: mtimecmp_d[31:0]  = merged;
        RegMtimecmpHi: mtimecmp_d[63:32] = merged;
        RegMtimeLo:    mtime_d           = {mtime_q[63:32], merged};
        RegMtimeHi:    mtime_d           = {merged, mtime_q[31:0]};
        default:       ;
      endcase
    end
  end

  // Register state, one-cycle bus response and registered interrupt levels.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tim_intr_q <= 1'b0;
      sw_intr_q  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rvalid_q   <= bus_req_i;
      rdata_q    <= rd_en ? cur_val : '0;
      err_q      <= bus_req_i & (sel == RegNone);
      tim_intr_q <= (mtime_q >= mtimecmp_q);
      sw_intr_q  <= msip_q;
    end
  end

  assign bus_gnt_o    = bus_req_i;
  assign bus_rvalid_o = rvalid_q;
  assign bus_rdata_o  = DataWidth'(rdata_q);
  assign bus_err_o    = err_q;
  assign tim_intr_o   = tim_intr_q;
  assign sw_intr_o    = sw_intr_q;

endmodule

// File: tb/tb_ristretto_core_local_interruptor.sv
// Scoreboard bench for the core-local interruptor. mtime is modelled as a closed form
// (base value + elapsed cycles / tick divider); interrupt levels are re-derived each cycle.
module tb_ristretto_core_local_interruptor;

`ifdef RISTRETTO_CLINT_PRESCALER_EN
  localparam int unsigned EFF_DIV = 4;
`else
  localparam int unsigned EFF_DIV = 1;
`endif

  logic        clk, rstn;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err, tim_intr, sw_intr;
  logic [31:0] bus_rdata;

  ristretto_core_local_interruptor #(
    .DataWidth  (32),
    .AddrWidth  (32),
    .PrescaleDiv(4)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus_req_i   (bus_req),
    .bus_we_i    (bus_we),
    .bus_addr_i  (bus_addr),
    .bus_be_i    (bus_be),
    .bus_wdata_i (bus_wdata),
    .bus_gnt_o   (bus_gnt),
    .bus_rvalid_o(bus_rvalid),
    .bus_rdata_o (bus_rdata),
    .bus_err_o   (bus_err),
    .tim_intr_o  (tim_intr),
    .sw_intr_o   (sw_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; cycle c is the period ending at posedge c+1.
  longint unsigned cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference model state.
  logic [63:0]     m_base, m_cmp;
  longint unsigned m_base_cyc;
  logic            m_msip;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  logic prev_tim, prev_sw;

  function automatic logic [63:0] mtime_at(input longint unsigned c);
    return m_base + 64'((c - m_base_cyc) / EFF_DIV);
  endfunction

  task automatic model_reset();
    m_base     = '0;
    m_base_cyc = 0;
    m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip     = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus access in one cycle; the expected response goes onto the scoreboard.
  task automatic bus(input logic we, input logic [15:0] off, input logic [3:0] be,
                     input logic [31:0] wdata);
    longint unsigned w;
    logic [15:0] upper;
    logic [63:0] mt;
    logic [31:0] cur, nv;
    logic        mapped;
    exp_t        e;
    upper = 16'($urandom);
    @(negedge clk);
    w         = cyc;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = {upper, off};
    bus_be    = be;
    bus_wdata = wdata;
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    mt     = mtime_at(w);
    mapped = 1'b1;
    case (off)
      16'h0000: cur = {31'b0, m_msip};
      16'h4000: cur = m_cmp[31:0];
      16'h4004: cur = m_cmp[63:32];
      16'hBFF8: cur = mt[31:0];
      16'hBFFC: cur = mt[63:32];
      default: begin cur = '0; mapped = 1'b0; end
    endcase
    e.err = ~mapped;
    if (we) begin
      e.rdata = '0;
      nv = cur;
      for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wdata[8*b +: 8];
      case (off)
        16'h0000: m_msip = nv[0];
        16'h4000: m_cmp[31:0] = nv;
        16'h4004: m_cmp[63:32] = nv;
        16'hBFF8: begin m_base = {mt[63:32], nv}; m_base_cyc = w + 1; end
        16'hBFFC: begin m_base = {nv, mt[31:0]}; m_base_cyc = w + 1; end
        default: ;
      endcase
    end else begin
      e.rdata = cur;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: bus responses against the scoreboard, interrupt levels against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      check("rvalid_in_reset", bus_rvalid, 1'b0);
      prev_tim = 1'b0;
      prev_sw  = 1'b0;
    end else begin
      check("gnt", bus_gnt, bus_req);
      if (bus_rvalid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rvalid", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("rdata", bus_rdata, e.rdata);
          check("err", bus_err, e.err);
        end
      end else if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("missing_rvalid", 1'b0, 1'b1);
      end
      check("tim_intr", tim_intr, prev_tim);
      check("sw_intr", sw_intr, prev_sw);
      prev_tim = (mtime_at(cyc) >= m_cmp);
      prev_sw  = m_msip;
    end
  end

  logic [15:0] offs [7];

  initial begin
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1000, 16'h0004};
    rstn = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    // Reset values.
    idle(3);
    bus(1'b0, 16'h4000, 4'h0, 32'h0);
    bus(1'b0, 16'h4004, 4'h0, 32'h0);
    bus(1'b0, 16'h0000, 4'h0, 32'h0);

    // Timer compare: rise one cycle after match, fall after raising mtimecmp.
    bus(1'b1, 16'h4004, 4'hF, 32'h0);
    bus(1'b1, 16'h4000, 4'hF, 32'h40);
    bus(1'b1, 16'hBFF8, 4'hF, 32'h0);
    idle(int'(32'h40 * EFF_DIV) + 20);
    check("tim_high_after_match", tim_intr, 1'b1);
    bus(1'b1, 16'h4000, 4'hF, 32'hFFFF_FFFF);
    idle(3);
    check("tim_low_after_raise", tim_intr, 1'b0);

    // Software interrupt and byte enables.
    bus(1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF);
    idle(2);
    bus(1'b0, 16'h0000, 4'h0, 32'h0);
    bus(1'b1, 16'h0000, 4'b1110, 32'h0);
    idle(2);
    bus(1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFE);
    idle(3);

    // Lo->hi carry and 64-bit wrap.
    bus(1'b1, 16'hBFFC, 4'hF, 32'h0);
    bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE);
    idle(int'(3 * EFF_DIV));
    bus(1'b0, 16'hBFFC, 4'h0, 32'h0);
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    bus(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF);
    bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    idle(int'(2 * EFF_DIV));
    bus(1'b0, 16'hBFFC, 4'h0, 32'h0);
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);

    // Unmapped offset.
    bus(1'b0, 16'h1000, 4'h0, 32'h0);
    bus(1'b1, 16'h1000, 4'hF, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) bus(1'b0, offs[i], 4'h0, 32'h0);

    // Prescaler phase restart on mtime write.
    idle(2);
    bus(1'b1, 16'hBFF8, 4'hF, 32'h100);
    for (int k = 0; k < 6; k++) begin
      idle(k);
      bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
    end

    // Randomized traffic, back-to-back and with gaps.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] off;
      off = offs[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) off = 16'($urandom);
      bus(1'($urandom), off, 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // Reset during an in-flight request: no response, registers back to reset values.
    bus(1'b1, 16'h0000, 4'hF, 32'h1);
    bus(1'b1, 16'h4000, 4'hF, 32'h0);
    idle(3);
    check("sb_empty_pre_reset", sb_q.size(), 0);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h0000_4000;
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rvalid_dropped", bus_rvalid, 1'b0);
    bus_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    idle(2);
    bus(1'b0, 16'h0000, 4'h0, 32'h0);
    bus(1'b0, 16'h4000, 4'h0, 32'h0);
    bus(1'b0, 16'h4004, 4'h0, 32'h0);
    bus(1'b0, 16'hBFF8, 4'h0, 32'h0);

    idle(3);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
